rf_top: RTL and testbench

- Architectural register file that sits directly downstream of the writeback stage and consumes its RF write request and exception outputs.
- Holds the general-purpose registers, which decode reads through two read ports with same-cycle write bypass.
- Holds the exception registers rm0 (faulting PC) and rm1 (faulting address).
- Holds the privilege-mode bit, which is set on exception entry and cleared on iret.

---
 rtl/rf_top.sv | 76 +++++++
 tb/tb_rf_top.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/rf_top.sv
// rf_top: architectural GPR file with write bypass, exception registers rm0/rm1
// and the supervisor/user privilege bit driven by exception and iret commits.
module rf_top #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int PC_W     = 32,
    parameter int XADDR_W  = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  src1_addr,
    input  logic [ADDR_W-1:0]  src2_addr,
    output logic [DATA_W-1:0]  src1_data,
    output logic [DATA_W-1:0]  src2_data,
    input  logic               wb_write_en,
    input  logic [ADDR_W-1:0]  wb_dest,
    input  logic [DATA_W-1:0]  wb_data,
    input  logic               xcpt_valid,
    input  logic [PC_W-1:0]    xcpt_pc,
    input  logic [XADDR_W-1:0] xcpt_addr,
    input  logic               iret_valid,
    output logic [PC_W-1:0]    rm0_pc,
    output logic [XADDR_W-1:0] rm1_addr,
    output logic [PC_W-1:0]    iret_pc,
    output logic               priv_mode,
    output logic               xcpt_nested
);
    localparam logic [0:0] MODE_USER = 1'b0;
    localparam logic [0:0] MODE_SUP  = 1'b1;

    logic [DATA_W-1:0]  regs_q [NUM_REGS];
    logic [PC_W-1:0]    rm0_q, rm0_d;
    logic [XADDR_W-1:0] rm1_q, rm1_d;
    logic [0:0]         mode_q, mode_d;
    logic               nested_q, nested_d;
    logic               wr_en;

    // The excepting instruction must not commit, so its write is neither stored nor bypassed.
    assign wr_en = wb_write_en && !xcpt_valid && (wb_dest != '0);

    assign src1_data = (src1_addr == '0) ? '0 :
                       (wr_en && wb_dest == src1_addr) ? wb_data : regs_q[src1_addr];
    assign src2_data = (src2_addr == '0) ? '0 :
                       (wr_en && wb_dest == src2_addr) ? wb_data : regs_q[src2_addr];

    // Exception wins over a simultaneous iret.
    always_comb begin
        rm0_d    = xcpt_valid ? xcpt_pc : rm0_q;
        rm1_d    = xcpt_valid ? xcpt_addr : rm1_q;
        mode_d   = xcpt_valid ? MODE_SUP : iret_valid ? MODE_USER : mode_q;
        nested_d = xcpt_valid ? (nested_q || mode_q == MODE_SUP) : iret_valid ? 1'b0 : nested_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            rm0_q    <= '0;
            rm1_q    <= '0;
            mode_q   <= MODE_SUP;
            nested_q <= 1'b0;
        end else begin
            if (wr_en) regs_q[wb_dest] <= wb_data;
            rm0_q    <= rm0_d;
            rm1_q    <= rm1_d;
            mode_q   <= mode_d;
            nested_q <= nested_d;
        end
    end

    assign rm0_pc      = rm0_q;
    assign rm1_addr    = rm1_q;
    assign iret_pc     = rm0_q;
    assign priv_mode   = mode_q[0];
    assign xcpt_nested = nested_q;
endmodule

// File: tb/tb_rf_top.sv
// tb_rf_top: directed stimulus pushes expected values into a scoreboard queue;
// a monitor pops and compares them mid-cycle on the falling clock edge.
module tb_rf_top;
    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  src1_addr, src2_addr, wb_dest;
    logic [31:0] src1_data, src2_data, wb_data, xcpt_pc, xcpt_addr;
    logic [31:0] rm0_pc, rm1_addr, iret_pc;
    logic        wb_write_en, xcpt_valid, iret_valid, priv_mode, xcpt_nested;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] v;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam int S1 = 0, S2 = 1, RM0 = 2, RM1 = 3, IPC = 4, PRIV = 5, NEST = 6;

    rf_top dut (
        .clock(clock), .reset(reset),
        .src1_addr(src1_addr), .src2_addr(src2_addr),
        .src1_data(src1_data), .src2_data(src2_data),
        .wb_write_en(wb_write_en), .wb_dest(wb_dest), .wb_data(wb_data),
        .xcpt_valid(xcpt_valid), .xcpt_pc(xcpt_pc), .xcpt_addr(xcpt_addr),
        .iret_valid(iret_valid),
        .rm0_pc(rm0_pc), .rm1_addr(rm1_addr), .iret_pc(iret_pc),
        .priv_mode(priv_mode), .xcpt_nested(xcpt_nested)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            S1:      return src1_data;
            S2:      return src2_data;
            RM0:     return rm0_pc;
            RM1:     return rm1_addr;
            IPC:     return iret_pc;
            PRIV:    return {31'b0, priv_mode};
            default: return {31'b0, xcpt_nested};
        endcase
    endfunction

    task automatic expect_v(input string name, input int sel, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.v    = v;
        q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        exp_t e;
        logic [31:0] a;
        forever begin
            @(negedge clock);
            while (q.size() > 0) begin
                e = q.pop_front();
                a = actual(e.sel);
                n_tests++;
                if (a !== e.v) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, a, e.v);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        src1_addr = '0; src2_addr = '0; wb_dest = '0; wb_data = '0;
        wb_write_en = 1'b0; xcpt_valid = 1'b0; iret_valid = 1'b0;
        xcpt_pc = '0; xcpt_addr = '0;
        cyc();
        reset = 1'b0;
        expect_v("reset_priv", PRIV, 32'd1);
        expect_v("reset_rm0", RM0, 32'd0);
        expect_v("reset_rm1", RM1, 32'd0);
        expect_v("reset_nested", NEST, 32'd0);
        for (int i = 0; i < 16; i++) begin
            cyc();
            src1_addr = 5'(2 * i);
            src2_addr = 5'(2 * i + 1);
            expect_v($sformatf("reset_r%0d", 2 * i), S1, 32'd0);
            expect_v($sformatf("reset_r%0d", 2 * i + 1), S2, 32'd0);
        end
        cyc();
        wb_write_en = 1'b1; wb_dest = 5'd5; wb_data = 32'hDEADBEEF; src1_addr = 5'd5;
        expect_v("bypass_r5", S1, 32'hDEADBEEF);
        cyc();
        wb_write_en = 1'b0;
        expect_v("array_r5", S1, 32'hDEADBEEF);
        cyc();
        wb_write_en = 1'b1; wb_dest = 5'd0; wb_data = 32'h12345678; src1_addr = 5'd0; src2_addr = 5'd0;
        expect_v("r0_bypass_s1", S1, 32'd0);
        expect_v("r0_bypass_s2", S2, 32'd0);
        cyc();
        wb_write_en = 1'b0;
        expect_v("r0_after_s1", S1, 32'd0);
        expect_v("r0_after_s2", S2, 32'd0);
        cyc();
        iret_valid = 1'b1; wb_write_en = 1'b1; wb_dest = 5'd7; wb_data = 32'h11;
        expect_v("iret_pre_priv", PRIV, 32'd1);
        cyc();
        iret_valid = 1'b0; wb_write_en = 1'b0; src1_addr = 5'd7;
        expect_v("iret_user_priv", PRIV, 32'd0);
        expect_v("iret_write_r7", S1, 32'h11);
        cyc();
        xcpt_valid = 1'b1; xcpt_pc = 32'h1000; xcpt_addr = 32'h2004;
        wb_write_en = 1'b1; wb_dest = 5'd7; wb_data = 32'hAA;
        expect_v("xcpt_no_bypass", S1, 32'h11);
        cyc();
        xcpt_valid = 1'b0; wb_write_en = 1'b0;
        expect_v("xcpt_rm0", RM0, 32'h1000);
        expect_v("xcpt_rm1", RM1, 32'h2004);
        expect_v("xcpt_priv", PRIV, 32'd1);
        expect_v("xcpt_nested_clear", NEST, 32'd0);
        expect_v("xcpt_r7_kept", S1, 32'h11);
        cyc();
        iret_valid = 1'b1;
        expect_v("iret_pc", IPC, 32'h1000);
        cyc();
        iret_valid = 1'b0;
        expect_v("iret2_priv", PRIV, 32'd0);
        expect_v("iret2_pc", IPC, 32'h1000);
        cyc();
        iret_valid = 1'b1;
        cyc();
        iret_valid = 1'b0;
        expect_v("user_iret_noop", PRIV, 32'd0);
        expect_v("user_iret_nested", NEST, 32'd0);
        cyc();
        xcpt_valid = 1'b1; xcpt_pc = 32'h500; xcpt_addr = 32'h504;
        cyc();
        xcpt_pc = 32'h3000; xcpt_addr = 32'h3004;
        expect_v("first_xcpt_priv", PRIV, 32'd1);
        expect_v("first_xcpt_nested", NEST, 32'd0);
        expect_v("first_xcpt_rm0", RM0, 32'h500);
        cyc();
        iret_valid = 1'b1; xcpt_pc = 32'h4000; xcpt_addr = 32'h4008;
        expect_v("nested_rm0", RM0, 32'h3000);
        expect_v("nested_flag", NEST, 32'd1);
        cyc();
        xcpt_valid = 1'b0; iret_valid = 1'b0;
        expect_v("xi_priv", PRIV, 32'd1);
        expect_v("xi_nested", NEST, 32'd1);
        expect_v("xi_rm0", RM0, 32'h4000);
        expect_v("xi_rm1", RM1, 32'h4008);
        cyc();
        wb_write_en = 1'b1; wb_dest = 5'd9; wb_data = 32'h55; src1_addr = 5'd9; src2_addr = 5'd9;
        expect_v("dual_bypass_s1", S1, 32'h55);
        expect_v("dual_bypass_s2", S2, 32'h55);
        cyc();
        wb_write_en = 1'b0;
        #1 reset = 1'b1;
        expect_v("async_r9_s1", S1, 32'd0);
        expect_v("async_r9_s2", S2, 32'd0);
        expect_v("async_priv", PRIV, 32'd1);
        expect_v("async_nested", NEST, 32'd0);
        expect_v("async_rm0", RM0, 32'd0);
        expect_v("async_rm1", RM1, 32'd0);
        cyc();
        reset = 1'b0;
        wb_write_en = 1'b1; wb_dest = 5'd3; wb_data = 32'h7;
        cyc();
        wb_write_en = 1'b0; src1_addr = 5'd3;
        expect_v("post_reset_write", S1, 32'h7);
        for (int i = 0; i < 10 && q.size() > 0; i++) cyc();
        if (q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d checks pending, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
